spi_byte_sequencer: RTL and testbench
=====================================

SPI_BYTE_SEQUENCER -- requirements
Module: spi_byte_sequencer

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8, TX FIFO entries, power of 2.
REQ-002 SHALL have parameter RX_DEPTH, default 8, RX FIFO entries, power of 2.
REQ-003 SHALL have parameter CS_SETUP, default 2, cycles from cs_n_o low to first byte strobe and from last completion to cs_n_o high.
REQ-004 SHALL have parameter FILL_BYTE, default 8'h00, byte sent when TX FIFO is empty.
REQ-005 SHALL have parameter TIMEOUT, default 255, max WAIT cycles per byte.
REQ-006 sysClk_i  in  1  single system clock; all logic on its rising edge.
REQ-007 reset_i  in  1  asynchronous, active-high reset.
REQ-008 tx_wr_i  in  1  push tx_data_i into TX FIFO.
REQ-009 tx_data_i  in  8  byte to transmit.
REQ-010 tx_full_o  out  1  TX FIFO full.
REQ-011 rx_rd_i  in  1  pop RX FIFO head.
REQ-012 rx_data_o  out  8  RX FIFO head, show-ahead; 8'h00 when empty.
REQ-013 rx_empty_o  out  1  RX FIFO empty.
REQ-014 start_i  in  1  begin transaction of len_i bytes.
REQ-015 len_i  in  4  byte count 1..15; sampled on accepted start_i.
REQ-016 busy_o  out  1  high whenever state is not IDLE.
REQ-017 done_o  out  1  one-cycle pulse at transaction end.
REQ-018 error_o  out  1  sticky: timeout or RX overrun; cleared on accepted start_i.
REQ-019 cs_n_o  out  1  slave select, active low.
REQ-020 spi_wr_n_o  out  1  active-low one-cycle write strobe to SPI byte master.
REQ-021 spi_byte_o  out  8  byte to SPI byte master, valid while spi_wr_n_o low.
REQ-022 spi_byte_i  in  8  byte received by SPI byte master.
REQ-023 spi_complete_i  in  1  SPI byte master transfer complete; spi_byte_i valid same cycle.

Function
REQ-024 SHALL implement states IDLE, SETUP, LOAD, WAIT, HOLD, DONE.
REQ-025 IDLE: start_i high and len_i != 0 SHALL latch len_i into remaining counter, clear error_o, go SETUP; start_i with len_i == 0 SHALL be ignored.
REQ-026 start_i while busy_o high SHALL be ignored.
REQ-027 cs_n_o SHALL be low in SETUP, LOAD, WAIT, HOLD and high in IDLE, DONE.
REQ-028 SETUP SHALL last exactly CS_SETUP cycles, then go LOAD.
REQ-029 LOAD SHALL last one cycle: spi_wr_n_o low, spi_byte_o = TX head (popped) or FILL_BYTE if TX FIFO empty; then go WAIT.
REQ-030 WAIT: spi_complete_i high SHALL push spi_byte_i into RX FIFO, decrement remaining; go LOAD if remaining != 0 after decrement, else HOLD.
REQ-031 RX push while RX FIFO full SHALL drop the byte and set error_o; sequencing continues.
REQ-032 WAIT with no spi_complete_i for TIMEOUT consecutive cycles SHALL set error_o and go HOLD, abandoning remaining bytes; unsent TX bytes stay in FIFO.
REQ-033 HOLD SHALL last CS_SETUP cycles, then go DONE.
REQ-034 DONE SHALL last one cycle with done_o high, then go IDLE.
REQ-035 spi_complete_i outside WAIT SHALL be ignored.
REQ-036 Minimum per-byte latency: LOAD to next LOAD = 2 cycles when spi_complete_i arrives first WAIT cycle.
REQ-037 tx_wr_i while full SHALL be dropped (no error); simultaneous push and LOAD pop SHALL both take effect, count unchanged.
REQ-038 rx_rd_i while empty SHALL be ignored; simultaneous RX push and pop SHALL both take effect, count unchanged.
REQ-039 FIFO pointers SHALL wrap modulo depth; full/empty from extra-bit pointer compare.
REQ-040 spi_byte_o SHALL be 8'h00 when spi_wr_n_o is high.

Reset
REQ-041 reset_i high SHALL immediately force state IDLE, both FIFOs empty, counters 0, cs_n_o=1, spi_wr_n_o=1, spi_byte_o=0, busy_o=0, done_o=0, error_o=0, tx_full_o=0, rx_empty_o=1, rx_data_o=0.
REQ-042 reset_i asserted mid-transaction SHALL abort with cs_n_o high the same cycle; no done_o pulse.

Verification
REQ-043 Push A5,3C; start len=2; model completes 1 cycle after each strobe returning 11,22 -> strobes carry A5 then 3C, RX reads 11,22, one done_o, cs_n_o low CS_SETUP cycles before first strobe.
REQ-044 TX empty; start len=3 -> three strobes with 00, three RX bytes, done_o once.
REQ-045 RX FIFO pre-filled to 8; start len=1 -> byte dropped, error_o=1, done_o pulses; next start clears error_o.
REQ-046 Start len=1, model never completes -> after 255 WAIT cycles error_o=1, HOLD, done_o, IDLE.
REQ-047 Push 9 bytes -> tx_full_o after 8th, 9th dropped; start len=0 and start while busy -> no effect.
REQ-048 reset_i asserted during WAIT -> cs_n_o=1, busy_o=0, FIFOs empty immediately, no done_o.

Source files
------------

// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: frames chip-select around a burst of byte transfers, fed from a TX FIFO and collecting into an RX FIFO
module spi_byte_sequencer #(
  parameter int         TX_DEPTH  = 8,
  parameter int         RX_DEPTH  = 8,
  parameter int         CS_SETUP  = 2,
  parameter logic [7:0] FILL_BYTE = 8'h00,
  parameter int         TIMEOUT   = 255
) (
  input  logic       sysClk_i,
  input  logic       reset_i,
  input  logic       tx_wr_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_full_o,
  input  logic       rx_rd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_empty_o,
  input  logic       start_i,
  input  logic [3:0] len_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic       cs_n_o,
  output logic       spi_wr_n_o,
  output logic [7:0] spi_byte_o,
  input  logic [7:0] spi_byte_i,
  input  logic       spi_complete_i
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int CW  = $clog2(CS_SETUP + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [TAW:0]   r_tx_wp, r_tx_rp;
  logic [RAW:0]   r_rx_wp, r_rx_rp;
  logic [3:0]     r_rem;
  logic [CW-1:0]  r_cnt;
  logic [TW-1:0]  r_to;
  logic           r_err;

  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_start, w_tx_push, w_tx_pop, w_cpl, w_rx_push, w_rx_pop;
  logic w_cnt_end, w_to_end, w_timeout;

  assign w_tx_empty = r_tx_wp == r_tx_rp;
  assign w_tx_full  = (r_tx_wp[TAW] != r_tx_rp[TAW]) && (r_tx_wp[TAW-1:0] == r_tx_rp[TAW-1:0]);
  assign w_rx_empty = r_rx_wp == r_rx_rp;
  assign w_rx_full  = (r_rx_wp[RAW] != r_rx_rp[RAW]) && (r_rx_wp[RAW-1:0] == r_rx_rp[RAW-1:0]);
  assign w_start    = (r_state == S_IDLE) && start_i && (len_i != 4'd0);
  assign w_tx_push  = tx_wr_i && !w_tx_full;
  assign w_tx_pop   = (r_state == S_LOAD) && !w_tx_empty;
  assign w_cpl      = (r_state == S_WAIT) && spi_complete_i;
  assign w_rx_push  = w_cpl && !w_rx_full;
  assign w_rx_pop   = rx_rd_i && !w_rx_empty;
  assign w_cnt_end  = r_cnt == CW'(CS_SETUP - 1);
  assign w_to_end   = r_to == TW'(TIMEOUT - 1);
  assign w_timeout  = (r_state == S_WAIT) && !spi_complete_i && w_to_end;

  assign tx_full_o  = w_tx_full;
  assign rx_empty_o = w_rx_empty;
  assign rx_data_o  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[RAW-1:0]];
  assign busy_o     = r_state != S_IDLE;
  assign done_o     = r_state == S_DONE;
  assign error_o    = r_err;
  assign cs_n_o     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign spi_wr_n_o = r_state != S_LOAD;
  assign spi_byte_o = (r_state != S_LOAD) ? 8'h00 : w_tx_empty ? FILL_BYTE : r_tx_mem[r_tx_rp[TAW-1:0]];

  // next-state selection; a completion on the last timeout cycle still counts as a completion
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_start ? S_SETUP : S_IDLE;
      S_SETUP: w_next = w_cnt_end ? S_LOAD : S_SETUP;
      S_LOAD:  w_next = S_WAIT;
      S_WAIT:  w_next = spi_complete_i ? ((r_rem == 4'd1) ? S_HOLD : S_LOAD) : w_to_end ? S_HOLD : S_WAIT;
      S_HOLD:  w_next = w_cnt_end ? S_DONE : S_HOLD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge sysClk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // byte counter, setup/hold timer, per-byte timeout and sticky error
  always_ff @(posedge sysClk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rem <= 4'd0;
      r_cnt <= '0;
      r_to  <= '0;
      r_err <= 1'b0;
    end else begin
      r_rem <= w_start ? len_i : w_cpl ? r_rem - 4'd1 : r_rem;
      r_cnt <= ((r_state == S_SETUP || r_state == S_HOLD) && w_next == r_state) ? r_cnt + CW'(1) : '0;
      r_to  <= (r_state == S_WAIT && w_next == S_WAIT) ? r_to + TW'(1) : '0;
      r_err <= w_start ? 1'b0 : ((w_cpl && w_rx_full) || w_timeout) ? 1'b1 : r_err;
    end
  end

  // FIFO pointers carry one extra wrap bit to tell full from empty
  always_ff @(posedge sysClk_i or posedge reset_i) begin
    if (reset_i) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      r_tx_wp <= r_tx_wp + (TAW+1)'(w_tx_push);
      r_tx_rp <= r_tx_rp + (TAW+1)'(w_tx_pop);
      r_rx_wp <= r_rx_wp + (RAW+1)'(w_rx_push);
      r_rx_rp <= r_rx_rp + (RAW+1)'(w_rx_pop);
    end
  end

  // FIFO storage needs no reset; empty flags gate every read
  always_ff @(posedge sysClk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[TAW-1:0]] <= tx_data_i;
    if (w_rx_push) r_rx_mem[r_rx_wp[RAW-1:0]] <= spi_byte_i;
  end
endmodule

// File: tb/tb_spi_byte_sequencer.sv
// tb_spi_byte_sequencer: table vectors, directed corner cases and random bursts against a queue-based model
module tb_spi_byte_sequencer;
  localparam int CSS   = 2;
  localparam int TMO   = 255;
  localparam int DEPTH = 8;

  logic       sysClk_i = 1'b0;
  logic       reset_i, tx_wr_i, rx_rd_i, start_i, spi_complete_i;
  logic [7:0] tx_data_i, spi_byte_i;
  logic [3:0] len_i;
  logic       tx_full_o, rx_empty_o, busy_o, done_o, error_o, cs_n_o, spi_wr_n_o;
  logic [7:0] rx_data_o, spi_byte_o;

  spi_byte_sequencer dut (
    .sysClk_i(sysClk_i), .reset_i(reset_i), .tx_wr_i(tx_wr_i), .tx_data_i(tx_data_i),
    .tx_full_o(tx_full_o), .rx_rd_i(rx_rd_i), .rx_data_o(rx_data_o), .rx_empty_o(rx_empty_o),
    .start_i(start_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .cs_n_o(cs_n_o), .spi_wr_n_o(spi_wr_n_o), .spi_byte_o(spi_byte_o),
    .spi_byte_i(spi_byte_i), .spi_complete_i(spi_complete_i)
  );

  always #5 sysClk_i = ~sysClk_i;

  typedef struct {
    int n_push; int len; int dly; bit resp;
    bit exp_err; int exp_strobes; int exp_rx;
  } vec_t;

  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] txq[$], rxq[$];
  bit m_err;
  logic [7:0] resp_q[$], sb_q[$];
  int dly_q[$], sc_q[$];
  bit respond = 0, prev_cs = 1;
  int cs_fall, cs_rise, done_cyc, done_cnt, idle_byte_bad = 0, resp_cnt = 0;
  logic [7:0] resp_byte;

  // SPI byte master stand-in plus bus monitor, evaluated mid-cycle
  always @(negedge sysClk_i) begin
    cyc++;
    spi_complete_i = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        spi_complete_i = 1'b1;
        spi_byte_i = resp_byte;
      end
    end
    if (!spi_wr_n_o) begin
      sb_q.push_back(spi_byte_o);
      sc_q.push_back(cyc);
      if (respond && resp_q.size() > 0) begin
        resp_byte = resp_q.pop_front();
        resp_cnt = dly_q.pop_front();
      end
    end else if (spi_byte_o !== 8'h00) idle_byte_bad++;
    if (prev_cs && !cs_n_o) cs_fall = cyc;
    if (!prev_cs && cs_n_o) cs_rise = cyc;
    prev_cs = cs_n_o;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_cs_n", cs_n_o, 1);
    chk("rst_wr_n", spi_wr_n_o, 1);
    chk("rst_spi_byte", spi_byte_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_tx_full", tx_full_o, 0);
    chk("rst_rx_empty", rx_empty_o, 1);
    chk("rst_rx_data", rx_data_o, 0);
  endtask

  task automatic push_one(input logic [7:0] b);
    @(negedge sysClk_i);
    chk("tx_full", tx_full_o, int'(txq.size() == DEPTH));
    tx_wr_i = 1'b1;
    tx_data_i = b;
    if (txq.size() < DEPTH) txq.push_back(b);
    @(negedge sysClk_i);
    tx_wr_i = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge sysClk_i);
      chk("rx_empty", rx_empty_o, int'(rxq.size() == 0));
      if (rxq.size() == 0) begin
        chk("rx_data_empty", rx_data_o, 0);
        break;
      end
      chk("rx_data", rx_data_o, rxq[0]);
      rx_rd_i = 1'b1;
      void'(rxq.pop_front());
      n++;
      @(negedge sysClk_i);
      rx_rd_i = 1'b0;
    end
  endtask

  // one burst: the model pops TX bytes (or fill), appends responses to RX up to depth, and times each phase
  task automatic run_txn(input int len, input int dly, input bit resp, input bit poke, input bit seq);
    logic [7:0] rb[$], exp_sb[$];
    int dl[$];
    int nexp, waited;
    for (int i = 0; i < len; i++) begin
      rb.push_back(seq ? 8'(8'h11 * (i + 1)) : 8'($urandom));
      dl.push_back(dly != 0 ? dly : int'($urandom_range(1, 4)));
    end
    resp_q = rb;
    dly_q = dl;
    respond = resp;
    sb_q.delete();
    sc_q.delete();
    done_cnt = 0;
    cs_fall = -1;
    cs_rise = -1;
    @(negedge sysClk_i);
    chk("idle_before_start", busy_o, 0);
    start_i = 1'b1;
    len_i = 4'(len);
    m_err = 0;
    @(negedge sysClk_i);
    start_i = 1'b0;
    waited = 0;
    while (busy_o && waited < 2000) begin
      if (poke && waited == 3) begin
        start_i = 1'b1;
        len_i = 4'd9;
      end else start_i = 1'b0;
      @(negedge sysClk_i);
      waited++;
    end
    start_i = 1'b0;
    chk("txn_finished_in_budget", int'(waited < 2000), 1);
    nexp = resp ? len : 1;
    for (int i = 0; i < nexp; i++) exp_sb.push_back(txq.size() > 0 ? txq.pop_front() : 8'h00);
    if (resp) begin
      foreach (rb[i]) begin
        if (rxq.size() < DEPTH) rxq.push_back(rb[i]);
        else m_err = 1;
      end
    end else m_err = 1;
    chk("strobe_count", sb_q.size(), nexp);
    for (int i = 0; i < nexp && i < sb_q.size(); i++) chk("strobe_byte", sb_q[i], exp_sb[i]);
    chk("done_pulses", done_cnt, 1);
    chk("error_o", error_o, int'(m_err));
    if (sc_q.size() > 0) begin
      chk("cs_setup", sc_q[0] - cs_fall, CSS);
      if (resp && sc_q.size() == len) begin
        for (int i = 0; i < len - 1; i++) chk("byte_gap", sc_q[i+1] - sc_q[i], dl[i] + 1);
        chk("hold_len", done_cyc - sc_q[len-1], dl[len-1] + 1 + CSS);
      end else if (!resp) chk("timeout_len", done_cyc - sc_q[0], TMO + 1 + CSS);
    end
    chk("cs_rise_at_done", cs_rise, done_cyc);
  endtask

  initial begin
    vec_t vecs[6];
    int n;
    vecs[0] = '{3, 3, 1, 1, 0, 3, 3};
    vecs[1] = '{0, 3, 2, 1, 0, 3, 3};
    vecs[2] = '{2, 5, 3, 1, 0, 5, 5};
    vecs[3] = '{1, 15, 1, 1, 1, 15, 8};
    vecs[4] = '{2, 1, 1, 0, 1, 1, 0};
    vecs[5] = '{0, 1, 1, 1, 0, 1, 1};
    reset_i = 1'b0; tx_wr_i = 1'b0; rx_rd_i = 1'b0; start_i = 1'b0; spi_complete_i = 1'b0;
    tx_data_i = 8'h00; spi_byte_i = 8'h00; len_i = 4'd0;
    #2 reset_i = 1'b1;
    #1 chk_reset_vals();
    repeat (2) @(negedge sysClk_i);
    reset_i = 1'b0;

    push_one(8'hA5);
    push_one(8'h3C);
    run_txn(2, 1, 1, 0, 1);
    chk("h1_strobe0", sb_q[0], 8'hA5);
    chk("h1_strobe1", sb_q[1], 8'h3C);
    drain(n);
    chk("h1_rx_count", n, 2);

    foreach (vecs[v]) begin
      drain(n);
      for (int j = 0; j < vecs[v].n_push; j++) push_one(8'(8'h40 + j));
      run_txn(vecs[v].len, vecs[v].dly, vecs[v].resp, 0, 0);
      chk("vec_error", error_o, int'(vecs[v].exp_err));
      chk("vec_strobes", sb_q.size(), vecs[v].exp_strobes);
      drain(n);
      chk("vec_rx_count", n, vecs[v].exp_rx);
    end

    run_txn(8, 1, 1, 0, 0);
    run_txn(1, 1, 1, 0, 0);
    chk("overrun_error", error_o, 1);
    drain(n);
    run_txn(1, 1, 1, 0, 0);
    chk("error_cleared_by_start", error_o, 0);
    drain(n);

    for (int j = 0; j < 9; j++) push_one(8'(8'hC0 + j));
    @(negedge sysClk_i);
    chk("tx_full_after_8", tx_full_o, 1);
    start_i = 1'b1;
    len_i = 4'd0;
    @(negedge sysClk_i);
    start_i = 1'b0;
    @(negedge sysClk_i);
    chk("len0_ignored", busy_o, 0);
    run_txn(9, 1, 1, 1, 0);
    chk("ninth_dropped", sb_q[8], 8'h00);
    chk("tx_not_full", tx_full_o, 0);
    drain(n);

    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 5);
      for (int j = 0; j < n; j++) push_one(8'($urandom));
      run_txn($urandom_range(1, 15), 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, 0);
      if ($urandom_range(0, 3) != 0) drain(n);
    end

    run_txn(2, 1, 1, 0, 0);
    while (txq.size() < DEPTH) push_one(8'($urandom));
    respond = 0;
    @(negedge sysClk_i);
    start_i = 1'b1;
    len_i = 4'd3;
    @(negedge sysClk_i);
    start_i = 1'b0;
    n = 0;
    while (spi_wr_n_o && n < 20) begin
      @(negedge sysClk_i);
      n++;
    end
    chk("reset_test_strobe_seen", int'(n < 20), 1);
    repeat (3) @(negedge sysClk_i);
    chk("busy_in_wait", busy_o, 1);
    done_cnt = 0;
    reset_i = 1'b1;
    #1 chk_reset_vals();
    txq.delete();
    rxq.delete();
    @(negedge sysClk_i);
    reset_i = 1'b0;
    repeat (3) @(negedge sysClk_i);
    chk("no_done_after_reset", done_cnt, 0);
    chk("idle_spi_byte_zero", idle_byte_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
